// File: rtl/program_sequencer.sv
// Fetch/execute controller: walks the program memory via seletor and runs each
// instruction on an accumulator/operand pair, publishing results to a display register.
module program_sequencer #(
    parameter int ACC_W    = 8,
    parameter int PROG_LEN = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       seletor,
    input  logic [2:0]       funcao,
    input  logic [3:0]       valor,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] disp_out,
    output logic             disp_valid,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [3:0] LAST_ADDR = 4'(PROG_LEN - 1);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] b;
    logic [ACC_W-1:0] vext;
    logic [ACC_W:0]   sum_ab;
    logic [ACC_W:0]   sum_av;
    logic             last;

    // Unsigned add returning the carry-out in the extra MSB.
    function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] x,
                                                 input logic [ACC_W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    assign vext   = {{(ACC_W-4){1'b0}}, valor};
    assign sum_ab = add_carry(acc, b);
    assign sum_av = add_carry(acc, vext);
    assign last   = (seletor == LAST_ADDR);
    assign busy   = (state == FETCH) || (state == EXEC);
    assign done   = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALT: if (start) state_nxt = FETCH;
            FETCH:      state_nxt = EXEC;
            EXEC:       state_nxt = last ? HALT : FETCH;
            default:    state_nxt = IDLE;
        endcase
    end

    // Memory outputs are only looked at in EXEC, so X elsewhere cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seletor    <= '0;
            acc        <= '0;
            b          <= '0;
            disp_out   <= '0;
            disp_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            disp_valid <= 1'b0;
            case (state)
                IDLE, HALT: if (start) seletor <= '0;
                EXEC: begin
                    case (funcao)
                        3'b000: begin
                            acc <= '0;
                            b   <= vext;
                            ovf <= 1'b0;
                        end
                        3'b001: begin
                            acc <= sum_ab[ACC_W-1:0];
                            b   <= vext;
                            if (sum_ab[ACC_W]) ovf <= 1'b1;
                        end
                        3'b010: begin
                            acc <= sum_av[ACC_W-1:0];
                            if (sum_av[ACC_W]) ovf <= 1'b1;
                        end
                        3'b011: acc <= acc >> 1;
                        3'b100: begin
                            disp_out   <= acc;
                            disp_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                    if (!last) seletor <= seletor + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: three instances (PROG_LEN 7, 16, 1) fed by
// behavioural program memories, with hand-computed accumulator/display sequences.
module tb_program_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start7, start16, start1;
    logic [3:0] sel7, sel16, sel1;
    logic [2:0] f7, f16, f1;
    logic [3:0] v7, v16, v1;
    logic [7:0] acc7, disp7, acc16, disp16, acc1, disp1;
    logic       dv7, ovf7, busy7, done7;
    logic       dv16, ovf16, busy16, done16;
    logic       dv1, ovf1, busy1, done1;

    logic [2:0] mf7[16];
    logic [3:0] mv7[16];
    logic [2:0] mf16[16];
    logic [3:0] mv16[16];
    logic [2:0] mf1;
    logic [3:0] mv1;

    assign f7  = mf7[sel7];
    assign v7  = mv7[sel7];
    assign f16 = mf16[sel16];
    assign v16 = mv16[sel16];
    assign f1  = mf1;
    assign v1  = mv1;

    program_sequencer #(.ACC_W(8), .PROG_LEN(7)) u7 (
        .clk(clk), .rst(rst), .start(start7), .seletor(sel7), .funcao(f7), .valor(v7),
        .acc(acc7), .disp_out(disp7), .disp_valid(dv7), .ovf(ovf7), .busy(busy7), .done(done7));
    program_sequencer #(.ACC_W(8), .PROG_LEN(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .seletor(sel16), .funcao(f16), .valor(v16),
        .acc(acc16), .disp_out(disp16), .disp_valid(dv16), .ovf(ovf16), .busy(busy16), .done(done16));
    program_sequencer #(.ACC_W(8), .PROG_LEN(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .seletor(sel1), .funcao(f1), .valor(v1),
        .acc(acc1), .disp_out(disp1), .disp_valid(dv1), .ovf(ovf1), .busy(busy1), .done(done1));

    int n_cmp = 0;
    int n_bad = 0;
    int e7_acc[7], e7_disp[7], e7_dv[7];
    int e16_acc[16], e16_ovf[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog7(input int idx, input int f, input int v);
        mf7[idx] = 3'(f);
        mv7[idx] = 4'(v);
    endtask

    task automatic prog16(input int idx, input int f, input int v);
        mf16[idx] = 3'(f);
        mv16[idx] = 4'(v);
    endtask

    // Called just after the start edge; optionally pokes start at edge 5 (busy).
    task automatic run7(input bit poke);
        chk("u7_sel_at_start", 32'(sel7), 0);
        chk("u7_busy_at_start", 32'(busy7), 1);
        for (int k = 0; k < 7; k++) begin
            if (poke && k == 2) start7 = 1'b1;
            tick();
            start7 = 1'b0;
            chk($sformatf("u7_sel_exec%0d", k), 32'(sel7), 32'(k));
            chk($sformatf("u7_done_exec%0d", k), 32'(done7), 0);
            tick();
            chk($sformatf("u7_acc%0d", k), 32'(acc7), 32'(e7_acc[k]));
            chk($sformatf("u7_disp%0d", k), 32'(disp7), 32'(e7_disp[k]));
            chk($sformatf("u7_dv%0d", k), 32'(dv7), 32'(e7_dv[k]));
        end
        chk("u7_done_end", 32'(done7), 1);
        chk("u7_busy_end", 32'(busy7), 0);
        chk("u7_sel_end", 32'(sel7), 6);
        tick();
        chk("u7_dv_after", 32'(dv7), 0);
        chk("u7_done_hold", 32'(done7), 1);
    endtask

    task automatic run16();
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("u16_sel_exec%0d", k), 32'(sel16), 32'(k));
            chk($sformatf("u16_done_exec%0d", k), 32'(done16), 0);
            tick();
            chk($sformatf("u16_acc%0d", k), 32'(acc16), 32'(e16_acc[k]));
            chk($sformatf("u16_ovf%0d", k), 32'(ovf16), 32'(e16_ovf[k]));
        end
        chk("u16_done_end", 32'(done16), 1);
    endtask

    initial begin
        rst = 1'b1;
        start7 = 1'b0; start16 = 1'b0; start1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            prog7(i, 0, 0);
            prog16(i, 0, 0);
        end
        mf1 = 3'd0; mv1 = 4'd0;
        prog7(0, 0, 4); prog7(1, 1, 2); prog7(2, 1, 4); prog7(3, 1, 2);
        prog7(4, 2, 1); prog7(5, 3, 0); prog7(6, 4, 0);

        tick(); tick();
        chk("rst_sel", 32'(sel7), 0);
        chk("rst_acc", 32'(acc7), 0);
        chk("rst_disp", 32'(disp7), 0);
        chk("rst_dv", 32'(dv7), 0);
        chk("rst_ovf", 32'(ovf7), 0);
        chk("rst_busy", 32'(busy7), 0);
        chk("rst_done", 32'(done7), 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy7), 0);

        // Main program, with an ignored start while busy.
        e7_acc  = '{0, 4, 6, 10, 11, 5, 5};
        e7_disp = '{0, 0, 0, 0, 0, 0, 5};
        e7_dv   = '{0, 0, 0, 0, 0, 0, 1};
        start7 = 1'b1; tick(); start7 = 1'b0;
        run7(1'b1);

        // Restart from HALT gives the same result.
        e7_disp = '{5, 5, 5, 5, 5, 5, 5};
        start7 = 1'b1; tick(); start7 = 1'b0;
        run7(1'b0);

        // Asynchronous reset during EXEC of address 3.
        start7 = 1'b1; tick(); start7 = 1'b0;
        repeat (7) tick();
        chk("mid_sel3", 32'(sel7), 3);
        chk("mid_acc6", 32'(acc7), 6);
        #1 rst = 1'b1;
        #1;
        chk("arst_acc", 32'(acc7), 0);
        chk("arst_disp", 32'(disp7), 0);
        chk("arst_sel", 32'(sel7), 0);
        chk("arst_busy", 32'(busy7), 0);
        chk("arst_done", 32'(done7), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_idle", 32'(busy7), 0);
        chk("arst_acc_hold", 32'(acc7), 0);
        e7_disp = '{0, 0, 0, 0, 0, 0, 5};
        start7 = 1'b1; tick(); start7 = 1'b0;
        run7(1'b0);

        // Reserved opcodes 111/101 leave acc, b and disp_out untouched.
        prog7(0, 0, 3); prog7(1, 1, 5); prog7(2, 7, 9); prog7(3, 1, 1);
        prog7(4, 5, 7); prog7(5, 4, 0); prog7(6, 2, 2);
        e7_acc  = '{0, 3, 3, 8, 8, 8, 10};
        e7_disp = '{5, 5, 5, 5, 5, 8, 8};
        e7_dv   = '{0, 0, 0, 0, 0, 1, 0};
        start7 = 1'b1; tick(); start7 = 1'b0;
        run7(1'b0);

        // PROG_LEN=16: build 225, then wrap past 255 and clear ovf with clrld.
        prog16(0, 0, 0);
        for (int i = 1; i < 16; i++) prog16(i, 2, 15);
        for (int i = 0; i < 16; i++) begin
            e16_acc[i] = 15 * i;
            e16_ovf[i] = 0;
        end
        start16 = 1'b1; tick(); start16 = 1'b0;
        run16();

        prog16(0, 2, 15); prog16(1, 2, 15); prog16(2, 2, 15); prog16(3, 2, 1);
        prog16(4, 0, 0);
        for (int i = 5; i < 16; i++) prog16(i, 6, 15);
        e16_acc = '{240, 255, 14, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        e16_ovf = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        start16 = 1'b1; tick(); start16 = 1'b0;
        run16();

        // PROG_LEN=1: load 9, then a single disp.
        mf1 = 3'd2; mv1 = 4'd9;
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("u1_busy", 32'(busy1), 1);
        tick();
        chk("u1_sel", 32'(sel1), 0);
        chk("u1_done_early", 32'(done1), 0);
        tick();
        chk("u1_acc9", 32'(acc1), 9);
        chk("u1_done", 32'(done1), 1);
        mf1 = 3'd4; mv1 = 4'd0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        tick();
        chk("u1_dv_early", 32'(dv1), 0);
        chk("u1_done_early2", 32'(done1), 0);
        tick();
        chk("u1_disp", 32'(disp1), 9);
        chk("u1_dv", 32'(dv1), 1);
        chk("u1_done2", 32'(done1), 1);
        tick();
        chk("u1_dv_after", 32'(dv1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Reads the program memory and executes it. The program memory maps a 4-bit `seletor` address to a 3-bit `funcao` opcode and a 4-bit `valor` operand.
- Drives `seletor` from an internal program counter and latches `funcao`/`valor` one cycle later.
- Executes the instruction on an accumulator/operand register pair and updates a display register.
- Sits between the program memory and the display logic. It is the reader side of the memory's address/instruction interface.

Parameters:
- ACC_W, 8, accumulator and display width in bits (≥ 5).
- PROG_LEN, 7, number of instructions executed per run (1..16); addresses 0..PROG_LEN-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a run from address 0. Honoured only in IDLE or HALT.
- seletor  out  4  instruction address to program memory; registered.
- funcao  in  3  opcode from program memory.
- valor  in  4  operand from program memory.
- acc  out  ACC_W  accumulator.
- disp_out  out  ACC_W  display register.
- disp_valid  out  1  one-cycle pulse when disp_out updated.
- ovf  out  1  sticky carry-out flag of additions.
- busy  out  1  high in FETCH/EXEC.
- done  out  1  high in HALT.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; seletor=0, acc=0, internal b=0, disp_out=0.
  - disp_valid=0, ovf=0, busy=0, done=0.
  - Reset during a run aborts it with no partial update after the reset edge.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE / HALT + start=1 → FETCH.
  - seletor←0.
  - acc, b, disp_out and ovf are retained. Programs begin with clrld.
- FETCH (1 cycle):
  - seletor is stable. The memory must present valid funcao/valor before the next edge.
  - Next state is EXEC.
- EXEC (1 cycle): funcao/valor are sampled at the ending edge and executed (vext = valor zero-extended to ACC_W):
  - 000 clrld: acc←0, b←vext, ovf←0.
  - 001 addld: acc←acc+b, b←vext.
  - 010 add: acc←acc+vext.
  - 011 div2: acc←acc>>1 (logical, LSB discarded).
  - 100 disp: disp_out←acc, disp_valid=1 next cycle only.
  - 101..111: no operation.
- Additions wrap modulo 2^ACC_W; a carry-out sets ovf (sticky until clrld or reset).
- Same EXEC edge, program counter:
  - If seletor==PROG_LEN-1: → HALT, seletor held.
  - Else: seletor←seletor+1, → FETCH.
- Latency:
  - 2 cycles per instruction.
  - done rises 2·PROG_LEN cycles after the start edge.
- busy=1 exactly in FETCH/EXEC; done=1 exactly in HALT.
- start while busy is ignored (no restart, no queueing).
- Simultaneous rst and start: rst wins.
- funcao/valor are ignored outside EXEC. X on them outside EXEC must not propagate.

Test Plan:
- Program {0:clrld 4, 1:addld 2, 2:addld 4, 3:addld 2, 4:add 1, 5:div2, 6:disp}, start:
  - Acc sequence 0,4,6,10,11,5; disp_out=5 with a one-cycle disp_valid.
  - done=1 at cycle 14 after start; seletor stepped 0..6.
- ACC_W=8, program clrld 15, then 17× addld 15 (b stays 15) with PROG_LEN=16 truncation: check wrap.
  - Preload via clrld 0, then add 15 repeated: acc 255→add 15 gives acc=14, ovf=1.
  - A following clrld clears ovf.
- start pulsed while busy at cycle 5 → ignored, done still at cycle 14. start in HALT → rerun from seletor=0 with identical result.
- rst asserted mid-run (during EXEC of address 3) → outputs at reset values immediately, state IDLE. A later start runs to completion normally.
- Opcode 111 and 101 in program → acc, b, disp_out unchanged for that instruction; pc still advances.
- PROG_LEN=1, program {0:disp} → disp_valid pulse with disp_out=acc, done after 2 cycles.
